// File: rtl/sqrt_unit.sv
// sqrt_unit: integer square root engine (restoring, two radicand bits per iteration).
//
// Computes root = floor(sqrt(radicand)) and rem = radicand - root^2. An operation
// takes WIDTH cycles from the accepting edge. done then stays high for DONE_HOLD
// cycles, or less if init restarts the engine during DONE.
//
// Parameters:
//   WIDTH     radicand width in bits (even, >= 4)
//   DONE_HOLD cycles done stays high before returning to idle (>= 1)
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   init      start request, sampled in IDLE and DONE
//   radicand  operand, captured on the accepting edge
//   root      floor(sqrt(radicand)), WIDTH/2 bits
//   rem       radicand - root^2, WIDTH/2+1 bits
//   busy      high in SHIFT/TEST
//   done      high while the result is valid (DONE state)
//
// Optional feature macro: SQRT_ZERO_FAST_EN. When defined, an accepted zero
// radicand goes straight to DONE with a zero result and never raises busy.
module sqrt_unit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DONE_HOLD = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   radicand,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem,
  output logic               busy,
  output logic               done
);

  localparam int unsigned HalfW = WIDTH / 2;
  localparam int unsigned PW    = HalfW + 2;
  localparam int unsigned CntW  = $clog2(HalfW + 1);
  localparam int unsigned HoldW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StTest, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [PW-1:0]      p_q, p_d;
  logic [HalfW-1:0]   root_q, root_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               start;
  logic [PW-1:0]      trial;
  logic [PW-1:0]      p_shift;

  // Trial value (root << 2) | 1 and the partial remainder with the next two
  // operand bits appended. The partial remainder never exceeds 2*root, so the
  // shift cannot lose significant bits at PW width.
  assign trial   = {root_q, 2'b01};
  assign p_shift = {p_q[PW-3:0], op_q[WIDTH-1 -: 2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      p_q     <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      p_q     <= p_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    p_d     = p_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    start   = 1'b0;

    case (state_q)
      StIdle: start = init;
      StShift: begin
        p_d     = p_shift;
        op_d    = {op_q[WIDTH-3:0], 2'b00};
        state_d = StTest;
      end
      StTest: begin
        if (p_q >= trial) begin
          p_d    = p_q - trial;
          root_d = {root_q[HalfW-2:0], 1'b1};
        end else begin
          root_d = {root_q[HalfW-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          hold_d  = '0;
        end else begin
          state_d = StShift;
        end
      end
      StDone: begin
        start = init;
        if (hold_q == HoldW'(DONE_HOLD - 1)) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Acceptance in IDLE or DONE; in DONE it preempts the hold countdown.
    if (start) begin
      op_d    = radicand;
      p_d     = '0;
      root_d  = '0;
      cnt_d   = CntW'(HalfW);
      hold_d  = '0;
      state_d = StShift;
`ifdef SQRT_ZERO_FAST_EN
      if (radicand == '0) begin
        state_d = StDone;
      end
`endif
    end
  end

  assign root = root_q;
  assign rem  = p_q[HalfW:0];
  assign busy = (state_q == StShift) || (state_q == StTest);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_sqrt_unit.sv
// Self-checking bench for sqrt_unit: a WIDTH=16/DONE_HOLD=10 instance driven from
// a vector table through a scoreboard queue, plus hand sequences for overlapping
// init, restart from DONE, reset mid-operation and continuous init; a second
// WIDTH=32/DONE_HOLD=1 instance covers the wide, short-hold configuration.
module tb_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        init16, init32;
  logic [15:0] rad16;
  logic [31:0] rad32;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic [15:0] root32;
  logic [16:0] rem32;
  logic        busy16, done16, busy32, done32;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [15:0] rad;
    logic [7:0]  root;
    logic [8:0]  rem;
  } vec_t;

  typedef struct {
    logic [7:0] root;
    logic [8:0] rem;
    int         due;
  } exp_t;

  exp_t q16[$];
  vec_t vecs[18];

  sqrt_unit #(.WIDTH(16), .DONE_HOLD(10)) u_d16 (
    .clk(clk), .rst(rst), .init(init16), .radicand(rad16),
    .root(root16), .rem(rem16), .busy(busy16), .done(done16)
  );

  sqrt_unit #(.WIDTH(32), .DONE_HOLD(1)) u_d32 (
    .clk(clk), .rst(rst), .init(init32), .radicand(rad32),
    .root(root32), .rem(rem32), .busy(busy32), .done(done32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: largest r with r*r <= x, by binary search.
  function automatic longint isqrt(input longint x);
    longint lo = 0, hi = 65536, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic bit fast_zero(input logic [15:0] r);
`ifdef SQRT_ZERO_FAST_EN
    return r == 16'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Drive init for one edge; queue the expected result with its due cycle.
  task automatic start16(input logic [15:0] r, input logic [7:0] eroot, input logic [8:0] erem,
                         input bit push);
    exp_t e;
    rad16  = r;
    init16 = 1'b1;
    tick();
    init16 = 1'b0;
    e.root = eroot;
    e.rem  = erem;
    e.due  = fast_zero(r) ? cyc : cyc + 16;
    if (push) q16.push_back(e);
    chk("busy_after_accept", {63'd0, busy16}, fast_zero(r) ? 64'd0 : 64'd1);
    chk("done_after_accept", {63'd0, done16}, fast_zero(r) ? 64'd1 : 64'd0);
  endtask

  task automatic collect16();
    exp_t e;
    int   guard = 0;
    while (!done16 && guard < 100) begin
      tick();
      guard++;
    end
    if (!done16) begin
      n_checks++;
      n_fail++;
      $display("FAIL done16_timeout: got done=0, expected done within 100 cycles");
    end else if (q16.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got a done pulse, expected none");
    end else begin
      e = q16.pop_front();
      chk("latency", 64'(cyc), 64'(e.due));
      chk("root", {56'd0, root16}, {56'd0, e.root});
      chk("rem", {55'd0, rem16}, {55'd0, e.rem});
    end
  endtask

  // Count remaining done-high cycles (done is already high, one counted).
  task automatic hold16(input int exp_len, input logic [7:0] eroot);
    int n = 0;
    while (done16 && n < 50) begin
      tick();
      n++;
    end
    chk("done_hold_len", 64'(n), 64'(exp_len));
    chk("busy_after_hold", {63'd0, busy16}, 64'd0);
    chk("root_held_idle", {56'd0, root16}, {56'd0, eroot});
  endtask

  initial begin
    int seen;
    int e32;
    logic [15:0] rr;

    rst = 1'b1; init16 = 1'b0; init32 = 1'b0; rad16 = '0; rad32 = '0;
    tick(); tick();
    chk("rst_root", {56'd0, root16}, 64'd0);
    chk("rst_rem", {55'd0, rem16}, 64'd0);
    chk("rst_busy", {63'd0, busy16}, 64'd0);
    chk("rst_done", {63'd0, done16}, 64'd0);
    rst = 1'b0;
    tick();

    vecs[0]  = '{16'd144,   8'd12,  9'd0};
    vecs[1]  = '{16'd65535, 8'd255, 9'd510};
    vecs[2]  = '{16'd2,     8'd1,   9'd1};
    vecs[3]  = '{16'd0,     8'd0,   9'd0};
    vecs[4]  = '{16'd1000,  8'd31,  9'd39};
    vecs[5]  = '{16'd1,     8'd1,   9'd0};
    vecs[6]  = '{16'd3,     8'd1,   9'd2};
    vecs[7]  = '{16'd4,     8'd2,   9'd0};
    vecs[8]  = '{16'd255,   8'd15,  9'd30};
    vecs[9]  = '{16'd256,   8'd16,  9'd0};
    vecs[10] = '{16'd65534, 8'd255, 9'd509};
    vecs[11] = '{16'd12345, 8'd111, 9'd24};
    vecs[12] = '{16'd65025, 8'd255, 9'd0};
    vecs[13] = '{16'd65024, 8'd254, 9'd508};
    for (int i = 14; i < 18; i++) begin
      rr = 16'($urandom_range(0, 65535));
      vecs[i].rad  = rr;
      vecs[i].root = 8'(isqrt(longint'(rr)));
      vecs[i].rem  = 9'(longint'(rr) - isqrt(longint'(rr)) * isqrt(longint'(rr)));
    end

    // Table: each vector runs to done, then the full hold back to idle.
    for (int i = 0; i < 18; i++) begin
      start16(vecs[i].rad, vecs[i].root, vecs[i].rem, 1'b1);
      collect16();
      hold16(10, vecs[i].root);
    end

    // init while busy is ignored, then a restart from DONE cuts done short.
    start16(16'd100, 8'd10, 9'd0, 1'b1);
    repeat (4) tick();
    rad16 = 16'd49; init16 = 1'b1;
    tick();
    init16 = 1'b0;
    collect16();
    tick(); tick();
    start16(16'd49, 8'd7, 9'd0, 1'b1);
    collect16();
    hold16(10, 8'd7);

    // Reset mid-operation: cleared outputs, no done afterwards.
    start16(16'd1000, 8'd0, 9'd0, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("midrst_root", {56'd0, root16}, 64'd0);
    chk("midrst_rem", {55'd0, rem16}, 64'd0);
    chk("midrst_busy", {63'd0, busy16}, 64'd0);
    chk("midrst_done", {63'd0, done16}, 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done16 || busy16) seen++;
    end
    chk("midrst_no_activity", 64'(seen), 64'd0);

    // init held high: one DONE cycle, then immediate restart.
    start16(16'd9, 8'd3, 9'd0, 1'b1);
    init16 = 1'b1;
    collect16();
    q16.push_back('{8'd3, 9'd0, cyc + 17});
    tick();
    chk("cont_done_drop", {63'd0, done16}, 64'd0);
    chk("cont_busy_restart", {63'd0, busy16}, 64'd1);
    init16 = 1'b0;
    collect16();
    hold16(10, 8'd3);

    // Wide instance, single-cycle done.
    rad32 = 32'hFFFF_FFFF; init32 = 1'b1;
    tick();
    init32 = 1'b0;
    e32 = cyc;
    seen = 0;
    while (!done32 && seen < 100) begin
      tick();
      seen++;
    end
    chk("w32_latency", 64'(cyc - e32), 64'd32);
    chk("w32_root", {48'd0, root32}, 64'd65535);
    chk("w32_rem", {47'd0, rem32}, 64'd131070);
    tick();
    chk("w32_done_len", {63'd0, done32}, 64'd0);
    chk("w32_root_held", {48'd0, root32}, 64'd65535);

    chk("scoreboard_drained", 64'(q16.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_unit.md
Name: sqrt_unit

Overview:
Parametrised integer square-root engine that combines controller and datapath in one block. It computes floor(sqrt(radicand)) and the remainder using the restoring digit-by-digit method, consuming two radicand bits per iteration. It sits as a memory-mapped peripheral core behind the soft-CPU bus wrapper. It is the generalised successor of the fixed-width sqrt ASM: configurable width and done-hold time, remainder output, a busy flag, and early restart.

Parameters:
WIDTH, 16, radicand width in bits; must be even and at least 4.
DONE_HOLD, 10, number of cycles done stays high before returning to IDLE; minimum 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
init  in  1  start request; sampled in IDLE and DONE
radicand  in  WIDTH  operand; captured on the accepting edge
root  out  WIDTH/2  floor(sqrt(radicand))
rem  out  WIDTH/2+1  radicand minus root squared
busy  out  1  high while an operation is in progress (SHIFT/TEST)
done  out  1  result valid; high for DONE_HOLD cycles

Behaviour:
- Reset (rst high at an edge): state IDLE; root=0, rem=0, busy=0, done=0. Internal operand shift register, partial remainder, iteration counter and hold counter all cleared. Reset overrides everything, including an operation in progress; no result is produced.
- States: IDLE, SHIFT, TEST, DONE.
- IDLE: if init=1, capture radicand, clear partial remainder and root, load iteration counter with WIDTH/2, go to SHIFT. Otherwise stay.
- SHIFT:
  - Shift the top two operand bits into the partial remainder: P = (P<<2) | top2.
  - Operand register shifts left by 2.
  - Go to TEST.
- TEST:
  - Trial value T = (root<<2) | 1.
  - If P >= T: P = P - T and root = (root<<1) | 1. Else root = root<<1.
  - Decrement the counter. If it reaches 0, go to DONE and clear the hold counter. Else go to SHIFT.
- Widths: the partial remainder is held internally at WIDTH/2+2 bits. The compare and subtract use unsigned arithmetic at that width. rem reports the low WIDTH/2+1 bits, which never truncates because the final remainder is at most 2*root.
- Latency: done rises exactly WIDTH cycles after the edge that accepted init (WIDTH/2 iterations of 2 cycles each). WIDTH=16 gives 16 cycles.
- DONE:
  - done=1 and busy=0. The hold counter increments each cycle; when it reaches DONE_HOLD-1, return to IDLE.
  - init=1 in DONE is accepted exactly as in IDLE, which cuts done short. done is 0 in the following cycle.
- busy=1 in SHIFT and TEST only. init is ignored while busy, and a radicand change while busy has no effect.
- root and rem hold their final values through DONE and IDLE until the next accepted init.
  - Intermediate values are visible on root and rem while busy; consumers must qualify them with done.
- Boundaries:
  - radicand=0 gives root=0, rem=0.
  - radicand all-ones gives root all-ones and rem=2*root.
  - init held high continuously restarts immediately after each DONE cycle.
  - Unreachable state encodings go to IDLE.

Optional Feature:
SQRT_ZERO_FAST_EN.
- Defined: an accepted init with radicand=0 goes directly to DONE on the accepting edge, with root=0 and rem=0. done rises 1 cycle after acceptance, and busy is never asserted for that operation. Nonzero radicands are unaffected.
- Undefined: zero takes the full WIDTH-cycle path like any other operand.

Test Plan:
1. WIDTH=16, radicand=144, init pulse -> done after exactly 16 cycles; root=12, rem=0; done high for 10 cycles, then IDLE.
2. radicand=65535 -> root=255, rem=510; radicand=2 -> root=1, rem=1.
3. radicand=0 -> root=0, rem=0. done arrives at cycle 16 without the macro, and at cycle 1 with SQRT_ZERO_FAST_EN (busy never high).
4. Start with radicand=100, then pulse init with radicand=49 at cycle 5 -> second init ignored; root=10, rem=0; then re-init during DONE with 49 -> done drops the next cycle, and the new result is root=7, rem=0.
5. Assert rst at cycle 7 of an operation on radicand=1000 -> the next cycle shows IDLE with root=0, rem=0, busy=0, done=0, and no done pulse appears.
6. WIDTH=32, DONE_HOLD=1, radicand=4294967295 -> root=65535, rem=131070; done after 32 cycles, high for exactly 1 cycle.
